seq_detect_arbiter: RTL
=======================

Name: seq_detect_arbiter

Overview:
Shares one serial pattern-detector datapath between two parallel-word requesters. Each requester offers a WORD_W-bit word on a valid/ready handshake. A round-robin arbiter grants one word at a time; the controller shifts that word MSB-first through an internal Moore-style matcher for a PAT_LEN-bit pattern (default 10110). The block reports each match with the requester id and keeps a saturating match count per requester. It sits between word-oriented producers and the bit-serial detection logic.

Parameters:
WORD_W, 8, width of each request word (>= PAT_LEN)
PAT_LEN, 5, pattern length in bits (1..WORD_W)
PATTERN, 5'b10110, pattern to detect; bit PAT_LEN-1 is the first bit received
CNT_W, 8, width of each per-requester match counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 offers a word
req0_data  input  WORD_W  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle
req1_valid  input  1  requester 1 offers a word
req1_data  input  WORD_W  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle
serial_bit  output  1  bit currently presented to the matcher
serial_valid  output  1  serial_bit is meaningful
busy  output  1  a word is in progress (SHIFT or FLUSH)
grant_id  output  1  owner of the word in progress
match_pulse  output  1  one-cycle pulse: pattern completed
match_id  output  1  requester whose word produced the match
match_cnt0  output  CNT_W  saturating match count, requester 0
match_cnt1  output  CNT_W  saturating match count, requester 1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0. This includes match counters, grant_id, match_id and match_pulse.
  - Round-robin pointer last_grant is set to 1, so requester 0 wins the first contention.
  - Reset overrides everything, including mid-word. The word in progress is dropped; no match is reported for it and it is not re-queued.
- FSM has three states: IDLE, SHIFT, FLUSH.
- IDLE:
  - If only reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is combinational: it is high only in IDLE, only for the granted requester, and only while not in reset. The handshake completes at that edge.
  - On the handshake edge:
    - Load the word into the shift register.
    - Set grant_id = N and last_grant = N.
    - Clear the match history register and the history fill count.
    - Move to SHIFT.
  - With no valid input, stay in IDLE.
- SHIFT (WORD_W cycles):
  - serial_valid = 1.
  - serial_bit = the current MSB of the shift register. Bits go out word[WORD_W-1] first, word[0] last.
  - At each edge:
    - The shift register shifts left.
    - The history becomes {history[PAT_LEN-2:0], serial_bit}.
    - The fill count increments, saturating at PAT_LEN.
  - After the WORD_W-th bit, move to FLUSH.
- FLUSH (1 cycle): serial_valid = 0, then move to IDLE.
- Throughput: a word occupies 1 accept cycle + WORD_W + 1 cycles. For WORD_W = 8, the next handshake is possible 10 cycles after the previous one.
- Match (Moore, registered):
  - match_pulse is high in the cycle after the bit that completes the pattern was presented. The condition is evaluated on the updated history: fill == PAT_LEN and history == PATTERN.
  - Overlapping matches are all reported.
  - Matches never span two words, because history is cleared at every load.
  - A match completed by the last bit appears during FLUSH.
  - match_id = grant_id and is registered alongside match_pulse.
  - When match_pulse is 0, match_id holds its last value.
- Counters:
  - match_cnt[match_id] increments at the same edge that raises match_pulse, so the new value is visible in the same cycle as the pulse.
  - A counter at 2^CNT_W-1 stays there (saturates, never wraps).
- busy = state is SHIFT or FLUSH. grant_id holds its value until the next grant.
- A valid held without ready must keep its data stable. The controller never accepts a word while busy.

Test Plan:
- Accept and overlapping matches:
  - Stimulus: after reset, req0_valid=1, req0_data=8'b1011_0110 for one cycle (T).
  - Required: req0_ready=1 at T. serial_bit sequence 1,0,1,1,0,1,1,0 over T+1..T+8. match_pulse at T+6 and T+9 (FLUSH), match_id=0. match_cnt0=2, match_cnt1=0. IDLE at T+10.
- No match:
  - Stimulus: req1 sends 8'h00, then 8'hFF.
  - Required: no match_pulse, match_cnt1=0, each word busy exactly 9 cycles.
- Contention:
  - Stimulus: both valid held continuously from reset, req0_data=8'hB0, req1_data=8'h16.
  - Required: grants alternate 0,1,0,1. Both words produce matches (8'hB0 at bits 7..3, 8'h16 at bits 4..0). Counters increment per owner.
- Saturation:
  - Stimulus: CNT_W=2, req0 sends 8'b1011_0110 three times (6 matches).
  - Required: match_cnt0 reads 1,2,3,3,3,3 after each pulse, never wraps.
- Reset mid-word:
  - Stimulus: req0 sends 8'b1011_0110, rst high for one cycle at T+3.
  - Required: next cycle IDLE, serial_valid=0, busy=0, match_cnt0=0, no match_pulse from the dropped word. A held req0_valid is re-accepted at the first post-reset IDLE cycle.
- Cross-word isolation:
  - Stimulus: req0 sends 8'b0000_0101, then 8'b1000_0000 (a 10110 across the boundary would be 1,0,1 then 1,0).
  - Required: no match_pulse for either word.

Source files
------------

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - two-requester round-robin front end for a shared serial pattern matcher
// Words are shifted MSB-first through a registered matcher; matches are tagged with the owning requester.
module seq_detect_arbiter #(
    parameter int WORD_W = 8,
    parameter int PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              serial_bit,
    output logic              serial_valid,
    output logic              busy,
    output logic              grant_id,
    output logic              match_pulse,
    output logic              match_id,
    output logic [CNT_W-1:0]  match_cnt0,
    output logic [CNT_W-1:0]  match_cnt1
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int BW = $clog2(WORD_W + 1);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [BW-1:0]    LAST_BIT  = BW'(WORD_W - 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]         state;
    logic [WORD_W-1:0]  shreg;
    logic [BW-1:0]      bit_idx;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic               last_grant;

    logic               pick;
    logic               accept;
    logic               sbit;
    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill_next;
    logic               hit;

    // pick: requester that would win if a handshake happens this cycle
    always_comb begin
        pick      = (req0_valid && req1_valid) ? ~last_grant : (req1_valid && !req0_valid);
        accept    = (state == S_IDLE) && (req0_valid || req1_valid) && !rst;
        sbit      = shreg[WORD_W-1];
        hist_next = (hist << 1) | PAT_LEN'(sbit);
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        hit       = (state == S_SHIFT) && (fill_next == FILL_FULL) && (hist_next == PATTERN);
    end

    assign req0_ready   = accept && !pick;
    assign req1_ready   = accept && pick;
    assign serial_valid = (state == S_SHIFT);
    assign serial_bit   = serial_valid && sbit;
    assign busy         = (state == S_SHIFT) || (state == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            hist        <= '0;
            fill        <= '0;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            match_pulse <= 1'b0;
            match_id    <= 1'b0;
            match_cnt0  <= '0;
            match_cnt1  <= '0;
        end else begin
            match_pulse <= hit;
            // Counter bumps on the same edge as the pulse so both are visible together
            if (hit) begin
                match_id <= grant_id;
                if (grant_id) begin
                    if (match_cnt1 != CNT_MAX) match_cnt1 <= match_cnt1 + 1'b1;
                end else begin
                    if (match_cnt0 != CNT_MAX) match_cnt0 <= match_cnt0 + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg      <= pick ? req1_data : req0_data;
                        grant_id   <= pick;
                        last_grant <= pick;
                        hist       <= '0;
                        fill       <= '0;
                        bit_idx    <= '0;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg   <= shreg << 1;
                    hist    <= hist_next;
                    fill    <= fill_next;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) state <= S_FLUSH;
                end
                S_FLUSH: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
